// File: rtl/cpu_pkg.sv
// Shared LEGv8 datapath definitions: register-file geometry, the register
// index type used by decode and forwarding, and an index-to-one-hot helper.
package cpu_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int XZR_IDX   = 31;
  localparam int DATA_W    = 64;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  reg_onehot_t;

  // Single hot bit at position idx; used to build per-register write enables.
  function automatic reg_onehot_t idx_to_onehot(input reg_idx_t idx);
    reg_onehot_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/decoder5to32.sv
// 5-to-32 one-hot decoder with enable; drives the register-file write enables.
// With en_i low every output bit is low, so no register can be written.
module decoder5to32
  import cpu_pkg::*;
(
  input  logic        en_i,
  input  reg_idx_t    idx_i,
  output reg_onehot_t onehot_o
);

  // Decode the index into a single enable bit, gated by en_i.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = idx_to_onehot(idx_i);
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/regfile_32x64.sv
// 32 x N architectural register file for the LEGv8 pipeline: one write port,
// two combinational read ports, register ZERO_REG hardwired to zero (XZR).
// Optional build macro REGFILE_BYPASS_EN: when defined, a read of the register
// being written in the same cycle returns WriteData (write-through bypass);
// when undefined, reads see only stored values (1-cycle write-to-read latency).
module regfile_32x64
  import cpu_pkg::*;
#(
  parameter int N        = DATA_W,
  parameter int ZERO_REG = XZR_IDX
)(
  input  logic           clk,
  input  logic           reset,
  input  logic           RegWrite,
  input  logic [4:0]     WriteReg,
  input  logic [N-1:0]   WriteData,
  input  logic [4:0]     ReadReg1,
  input  logic [4:0]     ReadReg2,
  output logic [N-1:0]   ReadData1,
  output logic [N-1:0]   ReadData2
);

  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  // Flat view of all registers feeding the two 32:1 read muxes.
  logic [NUM_REGS-1:0][N-1:0] reg_bus_s;
  reg_onehot_t                we_s;
  logic                       wr_req_s;
  logic [N-1:0]               rd1_s;
  logic [N-1:0]               rd2_s;

  // Writes aimed at XZR are dropped before the decoder so no enable fires.
  assign wr_req_s = RegWrite && (WriteReg != ZERO_IDX);

  decoder5to32 u_wr_dec (
    .en_i     (wr_req_s),
    .idx_i    (WriteReg),
    .onehot_o (we_s)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      // XZR has no storage; its mux input is tied to zero.
      logic unused_we_s;
      assign unused_we_s  = we_s[i];
      assign reg_bus_s[i] = '0;
    end else begin : g_flop
      logic [N-1:0] data_d;
      logic [N-1:0] data_q;

      // Next state: load WriteData when this register's enable is hot.
      always_comb begin
        data_d = data_q;
        if (we_s[i]) begin
          data_d = WriteData;
        end else begin
          data_d = data_q;
        end
      end

      // Register storage; asynchronous reset clears it regardless of clk.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign reg_bus_s[i] = data_q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1_s;
  logic byp2_s;

  // Bypass is suppressed during reset so both ports keep reading zero.
  assign byp1_s = wr_req_s && !reset && (ReadReg1 == WriteReg);
  assign byp2_s = wr_req_s && !reset && (ReadReg2 == WriteReg);

  // Read muxes with same-cycle write-through from the write port.
  always_comb begin
    rd1_s = reg_bus_s[ReadReg1];
    rd2_s = reg_bus_s[ReadReg2];
    if (byp1_s) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = reg_bus_s[ReadReg1];
    end
    if (byp2_s) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = reg_bus_s[ReadReg2];
    end
  end
`else
  // Read muxes return stored values only; a same-cycle write is seen next cycle.
  always_comb begin
    rd1_s = reg_bus_s[ReadReg1];
    rd2_s = reg_bus_s[ReadReg2];
  end
`endif

  assign ReadData1 = rd1_s;
  assign ReadData2 = rd2_s;

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed, scoreboard-based bench for regfile_32x64 (either bypass build).
module tb_regfile_32x64;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model [32];
  int          vectors;
  int          miscompares;

  regfile_32x64 dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) model[k] = 64'h0;
  endtask

  // Read both ports combinationally and compare against the model.
  task automatic rd(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    ReadReg1 = r1;
    ReadReg2 = r2;
    push($sformatf("%s_rd1_x%0d", tag, r1), model[r1]);
    push($sformatf("%s_rd2_x%0d", tag, r2), model[r2]);
    #1;
    check(ReadData1);
    check(ReadData2);
  endtask

  // One write on the next rising edge.
  task automatic wr(input logic [4:0] idx, input logic [63:0] d);
    @(negedge clk);
    RegWrite  = 1'b1;
    WriteReg  = idx;
    WriteData = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    if (idx != 5'd31) model[idx] = d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear_model();
    reset     = 1'b1;
    RegWrite  = 1'b0;
    WriteReg  = 5'd0;
    WriteData = 64'h0;
    ReadReg1  = 5'd0;
    ReadReg2  = 5'd5;

    // Reset state.
    #3;
    push("reset_rd1", 64'h0);
    push("reset_rd2", 64'h0);
    check(ReadData1);
    check(ReadData2);
    @(negedge clk);
    reset = 1'b0;

    // Load X5, then assert reset mid-cycle with no clock edge.
    wr(5'd5, 64'hDEADBEEF_00000001);
    rd("x5_loaded", 5'd5, 5'd5);
    @(negedge clk);
    #2;
    ReadReg1 = 5'd5;
    reset    = 1'b1;
    #1;
    push("async_reset_x5", 64'h0);
    check(ReadData1);
    clear_model();
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) rd("post_reset", 5'(i), 5'(31 - i));

    // Basic write/read, neighbours untouched.
    wr(5'd3, 64'h0123456789ABCDEF);
    push("x3_const_rd1", 64'h0123456789ABCDEF);
    push("x3_const_rd2", 64'h0123456789ABCDEF);
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd3;
    #1;
    check(ReadData1);
    check(ReadData2);
    rd("x3_neigh", 5'd2, 5'd4);

    // XZR write is discarded, nothing else moves.
    wr(5'd7, 64'h55);
    wr(5'd31, 64'hFFFFFFFFFFFFFFFF);
    push("xzr_const", 64'h0);
    ReadReg1 = 5'd31;
    #1;
    check(ReadData1);
    for (int i = 0; i < 32; i++) rd("after_xzr", 5'(i), 5'(i));

    // Write disabled.
    @(negedge clk);
    RegWrite  = 1'b0;
    WriteReg  = 5'd7;
    WriteData = 64'hAA;
    @(posedge clk);
    #1;
    push("x7_nowrite", 64'h55);
    ReadReg1 = 5'd7;
    #1;
    check(ReadData1);

    // Same-cycle read of the write target.
    wr(5'd9, 64'h10);
    @(negedge clk);
    RegWrite  = 1'b1;
    WriteReg  = 5'd9;
    WriteData = 64'h20;
    ReadReg2  = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push("x9_same_cycle", 64'h20);
`else
    push("x9_same_cycle", 64'h10);
`endif
    #1;
    check(ReadData2);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    model[9] = 64'h20;
    rd("x9_after_edge", 5'd9, 5'd9);

    // Reset together with a write: reset wins, bypass suppressed.
    @(negedge clk);
    RegWrite  = 1'b1;
    WriteReg  = 5'd12;
    WriteData = 64'hCAFEF00D_12345678;
    ReadReg1  = 5'd12;
    ReadReg2  = 5'd9;
    reset     = 1'b1;
    #1;
    push("rst_wr_rd1", 64'h0);
    push("rst_wr_rd2", 64'h0);
    check(ReadData1);
    check(ReadData2);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    reset    = 1'b0;
    clear_model();
    rd("rst_wr_after", 5'd12, 5'd9);

    // Sweep X0..X30 on consecutive edges, then read back on both ports.
    for (int i = 0; i < 31; i++) wr(5'(i), 64'(i) * 64'h1111);
    for (int i = 0; i < 32; i++) rd("sweep", 5'(i), 5'(31 - i));

    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
